// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory-side blocks: response owner encoding and
// the in-flight tag carried alongside each SRAM access.
package cpu_bus_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Deepest SRAM read latency the tag pipe has to cover.
  localparam int RAM_LAT_MAX = 4;

  typedef struct packed {
    logic vld;
    logic owner;
  } resp_tag_t;

endpackage

// File: rtl/cpu_sram_arbiter_resp_tag_pipe.sv
// Delay line of response tags, one stage per cycle of SRAM latency.
// The last stage lines up with ram_rdata for the access it describes.
module resp_tag_pipe #(
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_vld,
  input  logic in_owner,
  output logic out_vld,
  output logic out_owner
);
  import cpu_bus_pkg::*;

  resp_tag_t stage [RAM_LAT];

  // Shift tags toward the output; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].vld   <= in_vld;
      stage[0].owner <= in_owner;
      for (int i = 1; i < RAM_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_vld   = stage[RAM_LAT-1].vld;
  assign out_owner = stage[RAM_LAT-1].owner;

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data
// access. Data normally wins; a streak counter bounds how long fetch can be
// starved. Responses come back in grant order, tagged by owner.
module cpu_sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  import cpu_bus_pkg::*;

  // Streak is 3 bits, so the starvation limit is truncated to that width.
  localparam logic [2:0] STREAK_LIM = 3'(STARVE_MAX);

  logic       gnt_d;
  logic       gnt_i;
  logic       starve_guard;
  logic [2:0] streak;
  logic       rsp_vld;
  logic       rsp_owner;

  // Per-cycle arbitration: data first unless fetch has waited STARVE_MAX grants.
  always_comb begin
    starve_guard = inst_req && (STARVE_MAX != 0) && (streak == STREAK_LIM);
    gnt_d        = data_req && !reset && !starve_guard;
    gnt_i        = inst_req && !reset && !gnt_d;
  end

  // Forward the granted request to the SRAM; bus idles at zero otherwise.
  always_comb begin
    ram_en    = gnt_d || gnt_i;
    ram_wen   = 4'h0;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (gnt_d) begin
      ram_wen   = data_wr ? data_wstrb : 4'h0;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
    end else if (gnt_i) begin
      ram_wen   = inst_wr ? inst_wstrb : 4'h0;
      ram_addr  = inst_addr;
      ram_wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = gnt_i;
  assign data_addr_ok = gnt_d;

  // Count consecutive data grants that made fetch wait; saturate at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= 3'd0;
    end else if (gnt_i || !inst_req) begin
      streak <= 3'd0;
    end else if (gnt_d && (streak != STREAK_LIM)) begin
      streak <= streak + 3'd1;
    end
  end

  resp_tag_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_resp_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_vld    (ram_en),
    .in_owner  (gnt_d ? OWNER_DATA : OWNER_INST),
    .out_vld   (rsp_vld),
    .out_owner (rsp_owner)
  );

  // Steer the response strobe to its owner; suppressed while in reset.
  always_comb begin
    inst_data_ok = rsp_vld && !reset && (rsp_owner == OWNER_INST);
    data_data_ok = rsp_vld && !reset && (rsp_owner == OWNER_DATA);
  end

  assign inst_rdata = ram_rdata;
  assign data_rdata = ram_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Drives three arbiters (RAM_LAT 1, 2, 3; STARVE_MAX 4) with identical
// stimulus, each backed by its own SRAM model. Grant expectations come from
// the vector table; response expectations come from a scoreboard of grants.
module tb_cpu_sram_arbiter;
  import cpu_bus_pkg::*;

  localparam int NI = 3;

  typedef struct {
    string       nm;
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  dws;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        egi;
    logic        egd;
  } vec_t;

  typedef struct {
    logic        owner;
    logic        is_wr;
    logic [31:0] rdata;
    int          gcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;

  logic        inst_addr_ok_a [NI];
  logic        inst_data_ok_a [NI];
  logic        data_addr_ok_a [NI];
  logic        data_data_ok_a [NI];
  logic        ram_en_a       [NI];
  logic [3:0]  ram_wen_a      [NI];
  logic [31:0] inst_rdata_a   [NI];
  logic [31:0] data_rdata_a   [NI];
  logic [31:0] ram_addr_a     [NI];
  logic [31:0] ram_wdata_a    [NI];
  logic [31:0] ram_rdata_a    [NI];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        sb [$];
  int          head [NI];
  logic [31:0] ref_mem [256];
  vec_t        vecs [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hA000_0000 | (32'(i) << 12) | (32'(i) ^ 32'h5A);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [31:0] mem     [256];
    logic [31:0] rd_pipe [LAT];

    initial for (int k = 0; k < 256; k++) mem[k] = init_word(k);

    always @(posedge clk) begin
      rd_pipe[0] <= mem[ram_addr_a[g][9:2]];
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      if (ram_en_a[g])
        for (int b = 0; b < 4; b++)
          if (ram_wen_a[g][b]) mem[ram_addr_a[g][9:2]][8*b +: 8] <= ram_wdata_a[g][8*b +: 8];
    end

    assign ram_rdata_a[g] = rd_pipe[LAT-1];

    cpu_sram_arbiter #(
      .ADDR_W     (32),
      .RAM_LAT    (LAT),
      .STARVE_MAX (4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_wstrb   (inst_wstrb),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok_a[g]),
      .inst_data_ok (inst_data_ok_a[g]),
      .inst_rdata   (inst_rdata_a[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok_a[g]),
      .data_data_ok (data_data_ok_a[g]),
      .data_rdata   (data_rdata_a[g]),
      .ram_en       (ram_en_a[g]),
      .ram_wen      (ram_wen_a[g]),
      .ram_addr     (ram_addr_a[g]),
      .ram_wdata    (ram_wdata_a[g]),
      .ram_rdata    (ram_rdata_a[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic vec_t v(string nm, logic rst, logic ir, logic [31:0] ia,
                             logic dr, logic dw, logic [3:0] dws, logic [31:0] da,
                             logic [31:0] dwd, logic egi, logic egd);
    vec_t t;
    t.nm = nm; t.rst = rst; t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw;
    t.dws = dws; t.da = da; t.dwd = dwd; t.egi = egi; t.egd = egd;
    return t;
  endfunction

  // One clock cycle: drive, check at the falling edge, record grant, advance.
  task automatic step(input vec_t t);
    logic        exp_en, exp_iok, exp_dok;
    logic [3:0]  exp_wen;
    logic [31:0] exp_addr, exp_wdata;
    exp_t        e;
    string       p;

    reset = t.rst;
    inst_req = t.ir; inst_wr = 1'b0; inst_wstrb = 4'h0; inst_addr = t.ia; inst_wdata = 32'h0;
    data_req = t.dr; data_wr = t.dw; data_wstrb = t.dws; data_addr = t.da; data_wdata = t.dwd;
    @(negedge clk);

    exp_en    = t.egi | t.egd;
    exp_addr  = t.egd ? t.da : (t.egi ? t.ia : 32'h0);
    exp_wen   = (t.egd && t.dw) ? t.dws : 4'h0;
    exp_wdata = t.egd ? t.dwd : 32'h0;

    for (int g = 0; g < NI; g++) begin
      p = $sformatf("%s/lat%0d", t.nm, g + 1);
      chk({p, "/inst_addr_ok"}, 32'(inst_addr_ok_a[g]), 32'(t.egi));
      chk({p, "/data_addr_ok"}, 32'(data_addr_ok_a[g]), 32'(t.egd));
      chk({p, "/ram_en"}, 32'(ram_en_a[g]), 32'(exp_en));
      chk({p, "/ram_wen"}, 32'(ram_wen_a[g]), 32'(exp_wen));
      chk({p, "/ram_addr"}, ram_addr_a[g], exp_addr);
      chk({p, "/ram_wdata"}, ram_wdata_a[g], exp_wdata);

      exp_iok = 1'b0;
      exp_dok = 1'b0;
      if (!t.rst && head[g] < sb.size() && sb[head[g]].gcyc + g + 1 == cyc) begin
        e = sb[head[g]];
        head[g]++;
        if (e.owner == OWNER_DATA) begin
          exp_dok = 1'b1;
          if (!e.is_wr) chk({p, "/data_rdata"}, data_rdata_a[g], e.rdata);
        end else begin
          exp_iok = 1'b1;
          if (!e.is_wr) chk({p, "/inst_rdata"}, inst_rdata_a[g], e.rdata);
        end
      end
      chk({p, "/inst_data_ok"}, 32'(inst_data_ok_a[g]), 32'(exp_iok));
      chk({p, "/data_data_ok"}, 32'(data_data_ok_a[g]), 32'(exp_dok));
    end

    if (t.egd) begin
      e.owner = OWNER_DATA; e.is_wr = t.dw; e.rdata = ref_mem[t.da[9:2]]; e.gcyc = cyc;
      sb.push_back(e);
      if (t.dw)
        for (int b = 0; b < 4; b++)
          if (t.dws[b]) ref_mem[t.da[9:2]][8*b +: 8] = t.dwd[8*b +: 8];
    end else if (t.egi) begin
      e.owner = OWNER_INST; e.is_wr = 1'b0; e.rdata = ref_mem[t.ia[9:2]]; e.gcyc = cyc;
      sb.push_back(e);
    end

    if (t.rst)
      for (int g = 0; g < NI; g++) head[g] = sb.size();

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input string nm, input int n);
    for (int k = 0; k < n; k++) step(v(nm, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    for (int g = 0; g < NI; g++) head[g] = 0;

    //              name     rst ir  ia            dr dw dws      da     dwd           egi egd
    vecs.push_back(v("rst0", 1, 0, 32'h0,        0, 0, 4'h0,    32'h0,  32'h0,        0, 0));
    vecs.push_back(v("rst1", 1, 1, 32'hbfc00000, 1, 0, 4'h0,    32'h100,32'h0,        0, 0));
    vecs.push_back(v("t1a",  0, 1, 32'hbfc00000, 0, 0, 4'h0,    32'h0,  32'h0,        1, 0));
    vecs.push_back(v("t1b",  0, 1, 32'hbfc00004, 0, 0, 4'h0,    32'h0,  32'h0,        1, 0));
    vecs.push_back(v("t2a",  0, 1, 32'hbfc00008, 1, 0, 4'h0,    32'h100,32'h0,        0, 1));
    vecs.push_back(v("t2b",  0, 1, 32'hbfc00008, 0, 0, 4'h0,    32'h0,  32'h0,        1, 0));
    vecs.push_back(v("t3w",  0, 0, 32'h0,        1, 1, 4'b0011, 32'h20, 32'h12345678, 0, 1));
    vecs.push_back(v("t3i",  0, 0, 32'h0,        0, 0, 4'h0,    32'h0,  32'h0,        0, 0));
    vecs.push_back(v("t3r",  0, 0, 32'h0,        1, 0, 4'h0,    32'h20, 32'h0,        0, 1));
    vecs.push_back(v("t4d1", 0, 1, 32'hbfc0000c, 1, 0, 4'h0,    32'h40, 32'h0,        0, 1));
    vecs.push_back(v("t4d2", 0, 1, 32'hbfc0000c, 1, 0, 4'h0,    32'h44, 32'h0,        0, 1));
    vecs.push_back(v("t4d3", 0, 1, 32'hbfc0000c, 1, 0, 4'h0,    32'h48, 32'h0,        0, 1));
    vecs.push_back(v("t4d4", 0, 1, 32'hbfc0000c, 1, 0, 4'h0,    32'h4c, 32'h0,        0, 1));
    vecs.push_back(v("t4i5", 0, 1, 32'hbfc0000c, 1, 0, 4'h0,    32'h50, 32'h0,        1, 0));
    vecs.push_back(v("t4d6", 0, 1, 32'hbfc00010, 1, 0, 4'h0,    32'h50, 32'h0,        0, 1));
    vecs.push_back(v("t4d7", 0, 1, 32'hbfc00010, 1, 0, 4'h0,    32'h54, 32'h0,        0, 1));
    vecs.push_back(v("t4d8", 0, 1, 32'hbfc00010, 1, 0, 4'h0,    32'h58, 32'h0,        0, 1));
    vecs.push_back(v("t4d9", 0, 1, 32'hbfc00010, 1, 0, 4'h0,    32'h5c, 32'h0,        0, 1));
    vecs.push_back(v("t4i10",0, 1, 32'hbfc00010, 1, 0, 4'h0,    32'h60, 32'h0,        1, 0));
    vecs.push_back(v("clr1", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h68, 32'h0,        0, 1));
    vecs.push_back(v("clr2", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h6c, 32'h0,        0, 1));
    vecs.push_back(v("clr3", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h70, 32'h0,        0, 1));
    vecs.push_back(v("clr4", 0, 0, 32'h0,        1, 0, 4'h0,    32'h74, 32'h0,        0, 1));
    vecs.push_back(v("clr5", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h78, 32'h0,        0, 1));
    vecs.push_back(v("clr6", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h7c, 32'h0,        0, 1));
    vecs.push_back(v("clr7", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h80, 32'h0,        0, 1));
    vecs.push_back(v("clr8", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h84, 32'h0,        0, 1));
    vecs.push_back(v("clr9", 0, 1, 32'hbfc00014, 1, 0, 4'h0,    32'h88, 32'h0,        1, 0));
    vecs.push_back(v("t6i1", 0, 1, 32'hbfc00018, 0, 0, 4'h0,    32'h0,  32'h0,        1, 0));
    vecs.push_back(v("t6d2", 0, 0, 32'h0,        1, 0, 4'h0,    32'h88, 32'h0,        0, 1));
    vecs.push_back(v("t6i3", 0, 1, 32'hbfc0001c, 0, 0, 4'h0,    32'h0,  32'h0,        1, 0));
    vecs.push_back(v("t6d4", 0, 0, 32'h0,        1, 0, 4'h0,    32'h8c, 32'h0,        0, 1));

    #1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    idle("t6drain", 4);

    // Reset lands while two reads are in flight; streak restarts from zero.
    step(v("t5d1", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'h90, 32'h0, 0, 1));
    step(v("t5d2", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'h94, 32'h0, 0, 1));
    step(v("t5rst",1, 1, 32'hbfc00024, 1, 0, 4'h0, 32'h98, 32'h0, 0, 0));
    step(v("t5d3", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'h98, 32'h0, 0, 1));
    step(v("t5d4", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'h9c, 32'h0, 0, 1));
    step(v("t5d5", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'ha0, 32'h0, 0, 1));
    step(v("t5d6", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'ha4, 32'h0, 0, 1));
    step(v("t5i7", 0, 1, 32'hbfc00024, 1, 0, 4'h0, 32'ha8, 32'h0, 1, 0));
    idle("t5drain", 5);

    for (int g = 0; g < NI; g++)
      chk($sformatf("drain/lat%0d/responses", g + 1), 32'(head[g]), 32'(sb.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
